imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 90 +++++++++
 tb/tb_imem_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, checksummed program into instruction memory, then releases the CPU reset
//   clk       : rising-edge clock
//   rst_f     : asynchronous active-low reset
//   start     : begins a session from IDLE or ERR
//   in_valid, in_data, in_ready : word stream (header N, N program words, checksum)
//   im_we, im_addr, im_wdata    : registered instruction-memory write port
//   cpu_rst_f : active-low processor reset, released once the program is verified
//   busy, done, err             : session status
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst_f,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, CSUM, DONE, ERR} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, n_q, n_d;
  logic [31:0]   sum_q, sum_d, im_wdata_q;
  logic [15:0]   im_addr_q;
  logic          im_we_q, im_we_d, cpu_rst_f_q, acc;
  assign busy      = state_q inside {HDR, LOAD, CSUM};
  assign in_ready  = busy;
  assign done      = state_q == DONE;
  assign err       = state_q == ERR;
  assign acc       = in_valid & in_ready;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign cpu_rst_f = cpu_rst_f_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    sum_d   = sum_q;
    im_we_d = 1'b0;
    case (state_q)
      IDLE, ERR: if (start) state_d = HDR;
      HDR: if (acc) begin
        state_d = (in_data == 32'd0 || in_data > 32'(MAX_WORDS)) ? ERR : LOAD;
        n_d     = IW'(in_data);
        idx_d   = '0;
        sum_d   = '0;
      end
      LOAD: if (acc) begin
        im_we_d = 1'b1;
        sum_d   = sum_q + in_data;
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == n_q - IW'(1)) ? CSUM : LOAD;
      end
      CSUM: if (acc) state_d = (in_data == sum_q) ? DONE : ERR;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      sum_q       <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_rst_f_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      sum_q       <= sum_d;
      im_we_q     <= im_we_d;
      cpu_rst_f_q <= state_d == DONE;
      if (im_we_d) begin
        im_addr_q  <= BASE_ADDR + 16'(idx_q);
        im_wdata_q <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: checks imem_loader (two instances, BASE_ADDR 0000 and FFFF) against a session-level model
module tb_imem_loader;
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2, M_ERR = 3, MAXW = 1024;
  logic        clk = 1'b0, rst_f = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        rdy0, we0, crst0, busy0, done0, err0;
  logic        rdy1, we1, crst1, busy1, done1, err1;
  logic [15:0] a0, a1;
  logic [31:0] d0, d1;
  int          tests = 0, fails = 0, mode = M_IDLE, tag = -1;
  logic        m_we = 1'b0;
  logic [15:0] h_a0 = '0, h_a1 = '0;
  logic [31:0] h_d = '0;
  logic [15:0] wlog0[$], wlog1[$];
  logic [31:0] wdat[$], ref_dat[$], q[$];
  always #5 clk = ~clk;
  imem_loader u0 (
    .clk(clk), .rst_f(rst_f), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .im_we(we0), .im_addr(a0), .im_wdata(d0), .cpu_rst_f(crst0),
    .busy(busy0), .done(done0), .err(err0)
  );
  imem_loader #(.BASE_ADDR(16'hFFFF)) u1 (
    .clk(clk), .rst_f(rst_f), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .im_we(we1), .im_addr(a1), .im_wdata(d1), .cpu_rst_f(crst1),
    .busy(busy1), .done(done1), .err(err1)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [5:0] exp_flags();
    return {mode == M_BUSY, mode == M_BUSY, mode == M_DONE, mode == M_ERR, mode == M_DONE, m_we};
  endfunction
  // Per-cycle comparison: a data word tagged k accepted on an edge must appear as a write the cycle after
  initial forever begin
    @(posedge clk);
    m_we = rst_f && in_valid && tag >= 0;
    if (m_we) begin
      h_a0 = 16'(tag);
      h_a1 = 16'hFFFF + 16'(tag);
      h_d  = in_data;
    end
    @(negedge clk);
    if (!rst_f) begin
      m_we = 1'b0;
      h_a0 = '0;
      h_a1 = '0;
      h_d  = '0;
    end
    chk("flags0", 32'({busy0, rdy0, done0, err0, crst0, we0}), 32'(exp_flags()));
    chk("flags1", 32'({busy1, rdy1, done1, err1, crst1, we1}), 32'(exp_flags()));
    chk("addr0", 32'(a0), 32'(h_a0));
    chk("addr1", 32'(a1), 32'(h_a1));
    chk("data0", d0, h_d);
    chk("data1", d1, h_d);
    if (we0) begin
      wlog0.push_back(a0);
      wdat.push_back(d0);
    end
    if (we1) wlog1.push_back(a1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (mode == M_IDLE || mode == M_ERR) mode = M_BUSY;
  endtask
  task automatic send(input logic [31:0] w, input int t);
    in_valid = 1'b1;
    in_data  = w;
    tag      = t;
    tick();
    in_valid = 1'b0;
    tag      = -1;
  endtask
  task automatic session(input logic [31:0] n, input logic [31:0] ws[$], input logic [31:0] cs,
                         input int maxgap, input bit mid);
    logic [31:0] s = '0;
    send(n, -1);
    if (n == 0 || n > MAXW) begin
      mode = M_ERR;
      return;
    end
    foreach (ws[i]) begin
      repeat ($urandom_range(maxgap, 0)) tick();
      if (mid && i == 1) pulse_start();
      send(ws[i], i);
      s += ws[i];
    end
    repeat ($urandom_range(maxgap, 0)) tick();
    send(cs, -1);
    mode = (cs == s) ? M_DONE : M_ERR;
  endtask
  task automatic rst_checks(input string nm);
    chk({nm, "_flags"}, 32'({busy0, rdy0, done0, err0, crst0, we0, busy1, rdy1, done1, err1, crst1, we1}), 32'd0);
    chk({nm, "_addr"}, {a0, a1}, 32'd0);
    chk({nm, "_data0"}, d0, 32'd0);
    chk({nm, "_data1"}, d1, 32'd0);
  endtask
  task automatic do_reset();
    #2 rst_f = 1'b0;
    mode = M_IDLE;
    #1 rst_checks("rst");
    tick();
    rst_f = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_checks("init");
    rst_f = 1'b1;
    tick();
    // nominal load
    pulse_start();
    q = {32'h11000001, 32'h22000002};
    session(2, q, 32'h33000003, 0, 0);
    chk("nom_done", 32'({done0, crst0, done1, crst1}), 32'hF);
    chk("nom_nwr", 32'(wlog0.size()), 32'd2);
    if (wlog0.size() >= 2 && wlog1.size() >= 2 && wdat.size() >= 2) begin
      chk("nom_a0", 32'(wlog0[0]), 32'h0000);
      chk("nom_a1", 32'(wlog0[1]), 32'h0001);
      chk("nom_b0", 32'(wlog1[0]), 32'hFFFF);
      chk("nom_b1", 32'(wlog1[1]), 32'h0000);
      chk("nom_d1", wdat[1], 32'h22000002);
    end
    pulse_start();
    chk("done_hold", 32'({done0, busy0}), 32'b10);
    do_reset();
    // bad checksum, then restart from ERR
    pulse_start();
    q = {32'h5};
    session(1, q, 32'h6, 0, 0);
    chk("bad_err", 32'({err0, crst0, err1, crst1}), 32'b1010);
    pulse_start();
    chk("restart", 32'({err0, busy0}), 32'b01);
    // header limits
    wlog0.delete();
    wlog1.delete();
    session(0, q, 32'h0, 0, 0);
    chk("n0_err", 32'(err0), 32'd1);
    pulse_start();
    session(MAXW + 1, q, 32'h0, 0, 0);
    chk("nbig_err", 32'(err0), 32'd1);
    chk("hdr_nowr", 32'(wlog0.size() + wlog1.size()), 32'd0);
    // address and checksum wrap
    pulse_start();
    q = {32'hFFFFFFFF, 32'h00000003};
    session(2, q, 32'h00000002, 0, 0);
    chk("wrap_done", 32'({done0, done1}), 32'b11);
    if (wlog1.size() >= 2) begin
      chk("wrap_a0", 32'(wlog1[0]), 32'hFFFF);
      chk("wrap_a1", 32'(wlog1[1]), 32'h0000);
    end
    do_reset();
    // stalls and mid-load start must not change the write stream
    q = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'h9ABCDEF0};
    wdat.delete();
    pulse_start();
    session(4, q, 32'hACF13567, 0, 0);
    chk("ref_done", 32'(done0), 32'd1);
    ref_dat = wdat;
    do_reset();
    wdat.delete();
    pulse_start();
    session(4, q, 32'hACF13567, 3, 1);
    chk("stall_done", 32'(done0), 32'd1);
    chk("stall_n", 32'(wdat.size()), 32'(ref_dat.size()));
    foreach (ref_dat[i]) if (i < wdat.size()) chk("stall_d", wdat[i], ref_dat[i]);
    do_reset();
    // reset after 3 of 5 words abandons the session
    pulse_start();
    send(32'd5, -1);
    for (int k = 0; k < 3; k++) send(32'h100 + 32'(k), k);
    do_reset();
    wlog0.delete();
    send(32'h0000_0200, -1);
    send(32'h0000_0201, -1);
    tick();
    chk("post_rst_nowr", 32'(wlog0.size()), 32'd0);
    pulse_start();
    q = {32'h77};
    session(1, q, 32'h77, 1, 0);
    chk("post_rst_done", 32'({done0, crst0}), 32'b11);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
